// File: rtl/parking_gate_arbiter.sv
// Single-lane parking gate arbiter: alternating-priority entry/exit grants, occupancy, open timeout.
// Optional PARK_STATS_EN adds entries_total and timeouts_total saturating counters.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16,
    parameter int TIMER_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_done,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic             timeout,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]      entries_total,
    output logic [7:0]       timeouts_total
`endif
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_ENTRY = 2'd1,
        GRANT_EXIT  = 2'd2,
        CLOSE       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_exit_q, last_exit_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               entry_ok, exit_ok, expired;

    assign occupancy   = occ_q;
    assign full        = (occ_q == CNT_W'(CAPACITY));
    assign empty       = (occ_q == '0);
    assign entry_grant = (state_q == GRANT_ENTRY);
    assign exit_grant  = (state_q == GRANT_EXIT);
    assign gate_open   = entry_grant | exit_grant;

    assign entry_ok = entry_req & ~full;
    assign exit_ok  = exit_req & ~empty;
    assign expired  = (timer_q == TIMER_W'(OPEN_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        last_exit_d = last_exit_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        timeout     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie, last_exit_q set means entry gets its turn
                if (entry_ok && (!exit_ok || last_exit_q)) begin
                    state_d     = GRANT_ENTRY;
                    last_exit_d = 1'b0;
                    timer_d     = '0;
                end else if (exit_ok) begin
                    state_d     = GRANT_EXIT;
                    last_exit_d = 1'b1;
                    timer_d     = '0;
                end
            end
            GRANT_ENTRY, GRANT_EXIT: begin
                timer_d = timer_q + 1'b1;
                if (pass_done) begin
                    state_d = CLOSE;
                    if (state_q == GRANT_ENTRY) begin
                        if (!full) occ_d = occ_q + 1'b1;
                    end else begin
                        if (!empty) occ_d = occ_q - 1'b1;
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = CLOSE;
                end
            end
            CLOSE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_exit_q <= 1'b1;
            timer_q     <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_exit_q <= last_exit_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] entries_q, entries_d;
    logic [7:0]  touts_q, touts_d;

    assign entries_total  = entries_q;
    assign timeouts_total = touts_q;

    always_comb begin
        entries_d = entries_q;
        touts_d   = touts_q;
        if (entry_grant && pass_done && entries_q != 16'hFFFF)
            entries_d = entries_q + 16'd1;
        if (timeout && touts_q != 8'hFF)
            touts_d = touts_q + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            touts_q   <= '0;
        end else begin
            entries_q <= entries_d;
            touts_q   <= touts_d;
        end
    end
`endif

endmodule
